bsg_manycore_array_reset_sequencer: RTL

BSG_MANYCORE_ARRAY_RESET_SEQUENCER -- requirements
Module: bsg_manycore_array_reset_sequencer

---
 rtl/bsg_manycore_pkg.sv | 23 ++
 rtl/bsg_manycore_array_reset_sequencer_sync.sv | 26 ++
 rtl/bsg_manycore_array_reset_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared types and helpers for the manycore array reset sequencer.
//   bsg_manycore_reset_seq_state_e : sequencer FSM state encoding
//   safe_clog2 / max2              : elaboration-time width helpers
package bsg_manycore_pkg;

    typedef enum logic [2:0] {
        RS_HOLD   = 3'd0,
        RS_IO_REL = 3'd1,
        RS_ROWS   = 3'd2,
        RS_RUN    = 3'd3,
        RS_SOFT   = 3'd4
    } bsg_manycore_reset_seq_state_e;

    // clog2 that never returns 0, so a 1-entry range still gets a 1-bit index
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_manycore_array_reset_sequencer_sync.sv
// Reset synchroniser: a chain of depth_p flops that is forced to all ones
// while reset_n_i is low and shifts in zeros once it is released.
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset
//   reset_o   : last chain stage, active-high synchronised reset
module bsg_manycore_array_reset_sequencer_sync #(
    parameter int depth_p = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic reset_o
);

    logic [depth_p-1:0] chain_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            chain_r <= '1;
        end else begin
            chain_r <= chain_r << 1;
        end
    end

    assign reset_o = chain_r[depth_p-1];

endmodule

// File: rtl/bsg_manycore_array_reset_sequencer.sv
// Staged reset release for a manycore array: IO row first, then each compute
// row one row_gap_p apart, followed by optional per-row soft resets.
//   clk_i              : clock
//   reset_n_i          : synchronous active-low reset
//   soft_reset_v_i     : soft-reset request valid
//   soft_reset_rows_i  : per-compute-row soft-reset mask (bit k = row k)
//   soft_reset_ready_o : request accepted when high together with valid
//   io_reset_o         : active-high reset per IO router
//   tile_reset_o       : active-high reset per tile, [row][col]
//   done_o             : all rows released and no soft reset in progress
//
// state     | meaning
// ----------+------------------------------------------------------------
// RS_HOLD   | synchronised reset active, everything held in reset
// RS_IO_REL | spare pass-through; behaves like the HOLD exit
// RS_ROWS   | IO released, compute rows released one per gap interval
// RS_RUN    | array running, soft-reset requests accepted
// RS_SOFT   | masked rows held in soft reset for soft_hold_p cycles
module bsg_manycore_array_reset_sequencer
    import bsg_manycore_pkg::*;
#(
    parameter int num_tiles_x_p = -1,
    parameter int num_tiles_y_p = -1,
    parameter int reset_depth_p = 3,
    parameter int row_gap_p     = 2,
    parameter int soft_hold_p   = 4,
    // clamped so that unset defaults still elaborate to legal widths
    localparam int cols_lp = (num_tiles_x_p > 0) ? num_tiles_x_p : 1,
    localparam int rows_lp = (num_tiles_y_p > 1) ? (num_tiles_y_p - 1) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            soft_reset_v_i,
    input  logic [rows_lp-1:0]              soft_reset_rows_i,
    output logic                            soft_reset_ready_o,
    output logic [cols_lp-1:0]              io_reset_o,
    output logic [rows_lp-1:0][cols_lp-1:0] tile_reset_o,
    output logic                            done_o
);

    localparam int cnt_w_lp = safe_clog2(max2(row_gap_p, soft_hold_p) + 1);
    localparam int idx_w_lp = safe_clog2(rows_lp);

    logic reset_r;

    bsg_manycore_array_reset_sequencer_sync #(
        .depth_p (reset_depth_p)
    ) reset_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reset_o   (reset_r)
    );

    bsg_manycore_reset_seq_state_e state_r, state_n;
    logic                io_r,    io_n;
    logic [rows_lp-1:0]  row_r,   row_n;
    logic                done_r,  done_n;
    logic                ready_r, ready_n;
    logic [cnt_w_lp-1:0] cnt_r,   cnt_n;
    logic [idx_w_lp-1:0] idx_r,   idx_n;
    logic [rows_lp-1:0]  mask_r,  mask_n;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= RS_HOLD;
            io_r    <= 1'b1;
            row_r   <= '1;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            cnt_r   <= '0;
            idx_r   <= '0;
            mask_r  <= '0;
        end else begin
            state_r <= state_n;
            io_r    <= io_n;
            row_r   <= row_n;
            done_r  <= done_n;
            ready_r <= ready_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            mask_r  <= mask_n;
        end
    end

    always_comb begin
        state_n = state_r;
        io_n    = io_r;
        row_n   = row_r;
        done_n  = done_r;
        ready_n = ready_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        mask_n  = mask_r;

        case (state_r)
            RS_HOLD, RS_IO_REL: begin
                if (!reset_r) begin
                    io_n    = 1'b0;
                    cnt_n   = cnt_w_lp'(row_gap_p);
                    idx_n   = '0;
                    state_n = RS_ROWS;
                end
            end

            RS_ROWS: begin
                // down-counter hits terminal count on the release edge itself
                if (cnt_r == cnt_w_lp'(1)) begin
                    row_n[idx_r] = 1'b0;
                    if (idx_r == idx_w_lp'(rows_lp - 1)) begin
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                        cnt_n   = '0;
                        state_n = RS_RUN;
                    end else begin
                        idx_n = idx_r + idx_w_lp'(1);
                        cnt_n = cnt_w_lp'(row_gap_p);
                    end
                end else begin
                    cnt_n = cnt_r - cnt_w_lp'(1);
                end
            end

            RS_RUN: begin
                if (soft_reset_v_i && ready_r) begin
                    mask_n = soft_reset_rows_i;
                    // an empty mask is accepted but changes nothing else
                    if (|soft_reset_rows_i) begin
                        row_n   = row_r | soft_reset_rows_i;
                        done_n  = 1'b0;
                        ready_n = 1'b0;
                        cnt_n   = cnt_w_lp'(soft_hold_p);
                        state_n = RS_SOFT;
                    end
                end
            end

            RS_SOFT: begin
                if (cnt_r == cnt_w_lp'(1)) begin
                    row_n   = row_r & ~mask_r;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    cnt_n   = '0;
                    state_n = RS_RUN;
                end else begin
                    cnt_n = cnt_r - cnt_w_lp'(1);
                end
            end

            default: begin
                state_n = RS_HOLD;
            end
        endcase

        // synchronised reset still active: pin everything to reset values
        if (reset_r) begin
            state_n = RS_HOLD;
            io_n    = 1'b1;
            row_n   = '1;
            done_n  = 1'b0;
            ready_n = 1'b0;
            cnt_n   = '0;
            idx_n   = '0;
            mask_n  = '0;
        end
    end

    // one register per row, fanned out only across that row's columns
    assign io_reset_o = {cols_lp{io_r}};

    for (genvar r = 0; r < rows_lp; r++) begin : g_row
        assign tile_reset_o[r] = {cols_lp{row_r[r]}};
    end

    assign done_o             = done_r;
    assign soft_reset_ready_o = ready_r;

endmodule
